// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package data_bus_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W    = 32;
  localparam int unsigned ARB_DATA_W    = 32;
  localparam int unsigned ARB_MASK_W    = ARB_DATA_W / 8;
  localparam int unsigned ARB_MAX_BURST = 4;

  // State encoding doubles as the owner output encoding.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arbState_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_MASK_W-1:0] mask;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } busReq_t;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Master-side and slave-side signals of the shared data port.
interface data_bus_arbiter_if #(
  parameter int unsigned ADDR_W = data_bus_arbiter_pkg::ARB_ADDR_W,
  parameter int unsigned DATA_W = data_bus_arbiter_pkg::ARB_DATA_W
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              m0_req;
  logic              m0_we;
  logic [MASK_W-1:0] m0_mask;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [MASK_W-1:0] m1_mask;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [MASK_W-1:0] s_mask;
  logic              s_we;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        owner;

  // Arbiter view: serves the masters, drives the slave port.
  modport slave (
    input  m0_req, m0_we, m0_mask, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_mask, m1_addr, m1_wdata,
    input  s_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_addr, s_wdata, s_mask, s_we, owner
  );

  // Environment view: masters plus the RAM/GPIO data port.
  modport master (
    output m0_req, m0_we, m0_mask, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_mask, m1_addr, m1_wdata,
    output s_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_addr, s_wdata, s_mask, s_we, owner
  );

endinterface

// File: rtl/data_bus_arbiter_mux.sv
// Owner-indexed master-to-slave request mux; write enable gated by the grant.
module data_bus_mux
  import data_bus_arbiter_pkg::*;
(
  input  arbState_t owner,
  input  busReq_t   m0,
  input  busReq_t   m1,
  input  logic      m0Gnt,
  input  logic      m1Gnt,
  output busReq_t   slv
);

  always_comb begin
    slv = '0;
    case (owner)
      ARB_OWN0: begin
        slv    = m0;
        slv.we = m0.we & m0Gnt;
      end
      ARB_OWN1: begin
        slv    = m1;
        slv.we = m1.we & m1Gnt;
      end
      default: slv = '0;
    endcase
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter with burst limit in front of the RAM/GPIO data port.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = ARB_MAX_BURST,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  data_bus_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  arbState_t        stateQ, stateD;
  logic [CNT_W-1:0] beatCnt, beatCntD;
  logic             last, lastD;

  logic              m0Gnt, m1Gnt;
  logic              m0Rvalid, m1Rvalid;
  logic [DATA_W-1:0] m0Rdata, m1Rdata;
  busReq_t           m0Bus, m1Bus, slvBus;
  logic [ADDR_W-1:0] sAddr;

  assign m0Gnt = (stateQ == ARB_OWN0) & bus.m0_req;
  assign m1Gnt = (stateQ == ARB_OWN1) & bus.m1_req;

  assign m0Bus = '{we: bus.m0_we, mask: bus.m0_mask, addr: bus.m0_addr, wdata: bus.m0_wdata};
  assign m1Bus = '{we: bus.m1_we, mask: bus.m1_mask, addr: bus.m1_addr, wdata: bus.m1_wdata};

  data_bus_mux uMux (
    .owner (stateQ),
    .m0    (m0Bus),
    .m1    (m1Bus),
    .m0Gnt (m0Gnt),
    .m1Gnt (m1Gnt),
    .slv   (slvBus)
  );

  assign sAddr         = slvBus.addr;
  assign bus.s_addr    = sAddr;
  assign bus.s_wdata   = slvBus.wdata;
  assign bus.s_mask    = slvBus.mask;
  assign bus.s_we      = slvBus.we;
  assign bus.owner     = 2'(stateQ);
  assign bus.m0_gnt    = m0Gnt;
  assign bus.m1_gnt    = m1Gnt;
  assign bus.m0_rvalid = m0Rvalid;
  assign bus.m1_rvalid = m1Rvalid;
  assign bus.m0_rdata  = m0Rdata;
  assign bus.m1_rdata  = m1Rdata;

  // last resets to M1 so M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ  <= ARB_IDLE;
      beatCnt <= '0;
      last    <= 1'b1;
    end else begin
      stateQ  <= stateD;
      beatCnt <= beatCntD;
      last    <= lastD;
    end
  end

  // Stay while requesting unless the other master waits and the burst is spent.
  always_comb begin
    stateD   = stateQ;
    beatCntD = beatCnt;
    lastD    = last;
    case (stateQ)
      ARB_IDLE: begin
        beatCntD = '0;
        if (bus.m0_req && bus.m1_req) stateD = last ? ARB_OWN0 : ARB_OWN1;
        else if (bus.m0_req)          stateD = ARB_OWN0;
        else if (bus.m1_req)          stateD = ARB_OWN1;
      end
      ARB_OWN0: begin
        lastD = 1'b0;
        if (bus.m0_req && (!bus.m1_req || beatCnt < CNT_W'(MAX_BURST - 1))) begin
          if (beatCnt != '1) beatCntD = beatCnt + CNT_W'(1);
        end else begin
          beatCntD = '0;
          stateD   = bus.m1_req ? ARB_OWN1 : ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        lastD = 1'b1;
        if (bus.m1_req && (!bus.m0_req || beatCnt < CNT_W'(MAX_BURST - 1))) begin
          if (beatCnt != '1) beatCntD = beatCnt + CNT_W'(1);
        end else begin
          beatCntD = '0;
          stateD   = bus.m0_req ? ARB_OWN0 : ARB_IDLE;
        end
      end
      default: begin
        stateD   = ARB_IDLE;
        beatCntD = '0;
      end
    endcase
  end

  // Registered read return; reset drops any in-flight rvalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m0Rvalid <= 1'b0;
      m1Rvalid <= 1'b0;
      m0Rdata  <= '0;
      m1Rdata  <= '0;
    end else begin
      m0Rvalid <= m0Gnt & ~bus.m0_we;
      m1Rvalid <= m1Gnt & ~bus.m1_we;
      if (m0Gnt && !bus.m0_we) m0Rdata <= bus.s_rdata;
      if (m1Gnt && !bus.m1_we) m1Rdata <= bus.s_rdata;
    end
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Two-master, one-slave arbiter that shares the single RAM/GPIO data port between the CPU data bus (M0) and a second requester (M1: DMA/boot loader). It sits between the masters and the address decoder/RAM data port. It uses a req/gnt handshake, round-robin priority and a burst limit so neither master starves. Read data is returned registered with a valid strobe.

Parameters:
MAX_BURST, 4, maximum consecutive granted beats for one master while the other master is requesting (>=1).
ADDR_W, 32, address width.
DATA_W, 32, data width; the mask width is DATA_W/8.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset.
m0_req  input  1  M0 requests a beat; held until the beat is granted.
m0_we  input  1  M0 write enable for the beat.
m0_mask  input  4  M0 byte write mask.
m0_addr  input  32  M0 address.
m0_wdata  input  32  M0 write data.
m0_gnt  output  1  M0 beat accepted this cycle.
m0_rvalid  output  1  M0 read data valid.
m0_rdata  output  32  M0 read data.
m1_req, m1_we, m1_mask, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the M0 ports, for M1.
s_addr  output  32  slave address.
s_wdata  output  32  slave write data.
s_mask  output  4  slave byte mask.
s_we  output  1  slave write enable.
s_rdata  input  32  slave read data; asynchronous (combinational) read.
owner  output  2  current owner: 00 idle, 01 M0, 10 M1.

Behaviour:
- FSM states: IDLE, OWN0, OWN1, held in a registered state. Support registers:
  - last: 1 bit, the last owner.
  - beat_cnt: clog2(MAX_BURST)+1 bits.
- Reset (reset==0 at a clock edge):
  - state=IDLE, last=1 (so M0 wins the first tie), beat_cnt=0.
  - All mx_rvalid=0, mx_rdata=0.
  - Any pending rvalid is dropped, including mid-burst.
- mx_gnt = (state==OWNx) & mx_req, combinational.
  - In OWNx the slave port mirrors master x combinationally, with s_we = mx_we & mx_gnt.
  - In IDLE the slave outputs are all 0 and s_we=0.
  - The non-owner's gnt is always 0.
- A beat completes on every cycle with gnt=1. Writes commit at that clock edge.
- Read return:
  - mx_rvalid is registered: mx_rvalid <= mx_gnt & ~mx_we.
  - mx_rdata <= s_rdata on such a beat and holds otherwise.
  - Latency: data arrives 1 cycle after the gnt cycle.
- Grant latency: req rising while in IDLE leads to gnt on the next cycle (1 cycle). Back-to-back beats within ownership have 0 bubbles.
- Next state from IDLE:
  - Both requesting: grant OWN(~last).
  - One requesting: grant that master.
  - None requesting: stay in IDLE.
- Next state from OWNx (other master = y):
  - mx_req & (~my_req | beat_cnt < MAX_BURST-1): stay; beat_cnt++.
  - Else if my_req: switch to OWNy, beat_cnt=0.
  - Else: IDLE, beat_cnt=0.
  - beat_cnt saturates and never wraps. With no competitor, the burst is unlimited.
- last is updated to x on each cycle spent in OWNx.
- If mx_req drops mid-ownership, gnt falls in the same cycle. The FSM leaves at the next edge with no extra beat issued.
- A master switch costs 0 idle cycles: OWN0 goes directly to OWN1.
- owner is a pure decode of state.

Decomposition:
- Shared constants go in the constants header:
  - state encodings ARB_IDLE=2'b00, ARB_OWN0=2'b01, ARB_OWN1=2'b10 (equal to the owner encoding);
  - the default MAX_BURST.
- One natural sub-module: data_bus_mux, a combinational owner-indexed master-to-slave mux.
- The FSM, burst counter and round-robin pointer stay in data_bus_arbiter.

Test Plan:
- Reset held low 2 cycles with both reqs high -> all gnt=0, rvalid=0, owner=00, s_we=0. After release, M0 granted on the first cycle (owner=01).
- M1 alone: write 0xDEADBEEF, mask 4'hF to 0x100, then read 0x100 -> gnt next cycle, s_we=1 only in the write gnt cycle. m1_rvalid=1 with m1_rdata=0xDEADBEEF one cycle after the read gnt.
- Both continuously requesting, MAX_BURST=4 -> gnt pattern M0×4, M1×4, M0×4 with no idle cycles between owners.
- M0 streaming alone for 10 cycles -> 10 consecutive gnts, and beat_cnt never forces a switch.
- M0 drops req in cycle 3 of a burst while M1 requests -> m0_gnt=0 that cycle, owner=10 next cycle, no extra slave write.
- reset asserted the cycle after an M0 read gnt -> m0_rvalid stays 0. The FSM returns to IDLE and resumes cleanly after release.
